// File: rtl/data_sync_tx_if.sv
// Handshake bundle between local source logic, the data_sync_tx block and the
// destination-domain synchronizer. "slave" is the view taken by data_sync_tx;
// "master" is the view of whatever drives words in and returns the ack.
interface data_sync_tx_if #(
  parameter int DWIDTH = 8
);
  logic [DWIDTH-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DWIDTH-1:0] tx_data;
  logic              tx_req;
  logic              ack_i;

  modport master (
    output s_data, s_valid, ack_i,
    input  s_ready, tx_data, tx_req
  );

  modport slave (
    input  s_data, s_valid, ack_i,
    output s_ready, tx_data, tx_req
  );
endinterface

// File: rtl/data_sync_tx.sv
// data_sync_tx: source side of a four-phase req/ack clock-domain crossing.
// A word accepted on s_valid/s_ready is registered onto tx_data and held while
// a level request (tx_req) is raised, the synchronized ack is seen high, the
// request is dropped and the ack is seen low again.
// Optional feature: define DSYNC_TX_TIMEOUT_EN to abort a request that has not
// been acknowledged within TIMEOUT cycles (err_timeout pulses for one cycle).
module data_sync_tx #(
  parameter int DWIDTH  = 8,
  parameter int STAGES  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rstn,
  data_sync_tx_if.slave bus,
  output logic          busy,
  output logic          err_timeout
);

  if (STAGES < 2 || TIMEOUT < 1) begin : g_param_check
    $error("data_sync_tx: STAGES must be >= 2 and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [STAGES-1:0]   ack_sync_q;
  logic [STAGES-1:0]   primed_q;
  logic                ack_s;
  logic                primed;
  logic                s_ready;
  logic                tx_req_q, tx_req_d;
  logic [DWIDTH-1:0]   tx_data_q, tx_data_d;

  assign ack_s  = ack_sync_q[STAGES-1];
  // The sync chain is cleared by reset, so its output is meaningless until it
  // has been refilled with real ack_i samples; primed marks that point so a
  // stale high ack cannot slip a word through right after reset.
  assign primed = primed_q[STAGES-1];

`ifdef DSYNC_TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             tmo_hit;

  // cnt_q counts completed REQ cycles; when it would reach TIMEOUT on this
  // edge without an ack, the request is abandoned.
  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  // Ack synchronizer and post-reset priming chain.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ack_sync_q <= '0;
      primed_q   <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[STAGES-2:0], bus.ack_i};
      primed_q   <= {primed_q[STAGES-2:0], 1'b1};
    end
  end

  // State, request and held data registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
    end
  end

`ifdef DSYNC_TX_TIMEOUT_EN
  // Timeout counter and one-cycle abort pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  // Next-state, accept and request decode.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    s_ready   = 1'b0;
`ifdef DSYNC_TX_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        s_ready = rstn && primed && !ack_s;
        if (bus.s_valid && s_ready) begin
          tx_data_d = bus.s_data;
          state_d   = REQ;
`ifdef DSYNC_TX_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      REQ: begin
`ifdef DSYNC_TX_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        // A synchronized ack always wins over a timeout on the same cycle.
        if (ack_s) begin
          state_d = REL;
        end
`ifdef DSYNC_TX_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = REL;
          err_d   = 1'b1;
        end
`endif
      end
      REL: begin
        if (!ack_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // The request is a registered copy of "next state is REQ", so it never
    // sees a combinational path from any input.
    tx_req_d = (state_d == REQ);
  end

  assign bus.s_ready = s_ready;
  assign bus.tx_req  = tx_req_q;
  assign bus.tx_data = tx_data_q;
  assign busy        = rstn && (state_q != IDLE);

`ifdef DSYNC_TX_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule
